bootstrap_loader: RTL



---
 rtl/bootstrap_pkg.sv | 47 ++++
 rtl/boot_write_strobe.sv | 50 +++++
 rtl/bootstrap_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bootstrap_pkg.sv
// ============================================================================
// Module      : bootstrap_pkg
// Description : Shared widths and state encodings for the control-store
//               bootstrap loader and its write-strobe sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bootstrap_pkg;

   localparam int BOOT_DATA_WIDTH = 8;
   localparam int BOOT_ADDR_WIDTH = 12;

   // Top-level loader states. LD_WRITE covers the SETUP/STROBE/HOLD phases,
   // which are sequenced by boot_write_strobe.
   localparam logic [2:0] LD_INIT_ENC  = 3'd0;
   localparam logic [2:0] LD_WAIT_ENC  = 3'd1;
   localparam logic [2:0] LD_WRITE_ENC = 3'd2;
   localparam logic [2:0] LD_CHECK_ENC = 3'd3;
   localparam logic [2:0] LD_DONE_ENC  = 3'd4;
   localparam logic [2:0] LD_ERROR_ENC = 3'd5;

   typedef enum logic [2:0] {
      LD_INIT  = LD_INIT_ENC,
      LD_WAIT  = LD_WAIT_ENC,
      LD_WRITE = LD_WRITE_ENC,
      LD_CHECK = LD_CHECK_ENC,
      LD_DONE  = LD_DONE_ENC,
      LD_ERROR = LD_ERROR_ENC
   } loader_state_t;

   // Write-strobe sequencer states.
   localparam logic [1:0] WS_IDLE_ENC   = 2'd0;
   localparam logic [1:0] WS_SETUP_ENC  = 2'd1;
   localparam logic [1:0] WS_STROBE_ENC = 2'd2;
   localparam logic [1:0] WS_HOLD_ENC   = 2'd3;

   typedef enum logic [1:0] {
      WS_IDLE   = WS_IDLE_ENC,
      WS_SETUP  = WS_SETUP_ENC,
      WS_STROBE = WS_STROBE_ENC,
      WS_HOLD   = WS_HOLD_ENC
   } strobe_state_t;

endpackage

`default_nettype wire

// File: rtl/boot_write_strobe.sv
// ============================================================================
// Module      : boot_write_strobe
// Description : Three-phase asynchronous SRAM write sequencer. A start pulse
//               runs SETUP (we high), STROBE (we low), HOLD (we high); o_done
//               pulses during HOLD. The caller holds address/data stable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_write_strobe
   import bootstrap_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_done,
   output logic o_n_we
);

   strobe_state_t state_q;
   strobe_state_t state_d;

   // State register; async reset drops any strobe in progress immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one cycle per phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WS_IDLE:   if (i_start) state_d = WS_SETUP;
         WS_SETUP:  state_d = WS_STROBE;
         WS_STROBE: state_d = WS_HOLD;
         WS_HOLD:   state_d = WS_IDLE;
         default:   state_d = WS_IDLE;
      endcase
   end

   // Outputs are decoded from the state register only.
   assign o_n_we = (state_q != WS_STROBE);
   assign o_done = (state_q == WS_HOLD);

endmodule

`default_nettype wire

// File: rtl/bootstrap_loader.sv
// ============================================================================
// Module      : bootstrap_loader
// Description : Loads COUNT bytes from a valid/ready stream into consecutive
//               control-store addresses, then drops N_BOOTED.
//               Optional feature macro: BOOTSTRAP_CHECKSUM_EN (trailing
//               checksum byte, mod-256 sum must be zero, else ERROR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bootstrap_loader
   import bootstrap_pkg::*;
#(
   parameter int ADDR_WIDTH = BOOT_ADDR_WIDTH,
   parameter int COUNT      = 4096
)(
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [BOOT_DATA_WIDTH-1:0] IN_DATA,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   output logic [ADDR_WIDTH-1:0]      BOOTSTRAP_ADDR,
   output logic [BOOT_DATA_WIDTH-1:0] BOOTSTRAP_DATA,
   output logic                       BOOTSTRAP_N_WE,
   output logic                       N_BOOTED,
   output logic                       BOOT_ERROR
);

   localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(COUNT - 1);

   loader_state_t                state_q;
   loader_state_t                state_d;
   logic [ADDR_WIDTH-1:0]        addr_q;
   logic [ADDR_WIDTH-1:0]        addr_d;
   logic [BOOT_DATA_WIDTH-1:0]   data_q;
   logic [BOOT_DATA_WIDTH-1:0]   data_d;
   logic                         w_accept;
   logic                         w_wr_done;

   assign w_accept = (state_q == LD_WAIT) && IN_VALID;

   boot_write_strobe u_strobe (
      .clk     (CLK),
      .rst     (RST),
      .i_start (w_accept),
      .o_done  (w_wr_done),
      .o_n_we  (BOOTSTRAP_N_WE)
   );

`ifdef BOOTSTRAP_CHECKSUM_EN
   logic [BOOT_DATA_WIDTH-1:0]   sum_q;
   logic [BOOT_DATA_WIDTH-1:0]   sum_d;
   logic [BOOT_DATA_WIDTH-1:0]   w_check_sum;

   assign w_check_sum = sum_q + IN_DATA;

   // Running mod-256 sum of every accepted data byte.
   always_comb begin
      sum_d = sum_q;
      if (w_accept) sum_d = sum_q + IN_DATA;
   end

   // Checksum accumulator register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sum_q <= '0;
      else     sum_q <= sum_d;
   end
`endif

   // State, address and data registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= LD_INIT;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic: accept, write, advance address or finish.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         LD_INIT: state_d = LD_WAIT;
         LD_WAIT: begin
            if (IN_VALID) begin
               data_d  = IN_DATA;
               state_d = LD_WRITE;
            end
         end
         LD_WRITE: begin
            if (w_wr_done) begin
               if (addr_q == c_last_addr) begin
`ifdef BOOTSTRAP_CHECKSUM_EN
                  state_d = LD_CHECK;
`else
                  state_d = LD_DONE;
`endif
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = LD_WAIT;
               end
            end
         end
`ifdef BOOTSTRAP_CHECKSUM_EN
         LD_CHECK: begin
            // The checksum byte is consumed here but never written out.
            if (IN_VALID) begin
               state_d = (w_check_sum == '0) ? LD_DONE : LD_ERROR;
            end
         end
`endif
         default: state_d = state_q;
      endcase
   end

   assign BOOTSTRAP_ADDR = addr_q;
   assign BOOTSTRAP_DATA = data_q;
   assign N_BOOTED       = (state_q != LD_DONE);
`ifdef BOOTSTRAP_CHECKSUM_EN
   assign IN_READY       = (state_q == LD_WAIT) || (state_q == LD_CHECK);
   assign BOOT_ERROR     = (state_q == LD_ERROR);
`else
   assign IN_READY       = (state_q == LD_WAIT);
   assign BOOT_ERROR     = 1'b0;
`endif

endmodule

`default_nettype wire
